decoder_seq_nxm: RTL and testbench
==================================

Name: decoder_seq_nxm

Overview:
Registered, parametrised N-to-M one-hot decoder. It has two operating modes: direct, which decodes a handshaked input code, and scan, which walks an internal index across all outputs with a programmable dwell time. It is the sequential successor of the combinational N×M decoder and targets display-digit multiplexing, row strobing and chip-select generation. Input codes out of range are flagged rather than silently aliased.

Parameters:
N, 4, width of input code and index.
NUM_OUT, 1<<N, number of one-hot outputs; legal range 2..2^N.
DWELL, 4, clock cycles each output stays active in scan mode; ≥1.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  block enable; low forces IDLE.
mode  in  1  0 = direct decode, 1 = auto scan.
in_valid  in  1  input code valid (direct mode).
in  in  N  input code.
in_ready  out  1  block accepts code this cycle.
out  out  NUM_OUT  one-hot decoded output, registered.
out_valid  out  1  out holds a valid decode.
idx  out  N  index currently driven on out.
wrap  out  1  one-cycle pulse when scan index wraps to 0.
err  out  1  one-cycle pulse: accepted code ≥ NUM_OUT.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE. out, out_valid, idx, wrap, err, the dwell counter and in_ready are all 0.
- FSM states are IDLE, DIRECT and SCAN, evaluated each rising clk edge:
  - IDLE: if en=1, go to DIRECT when mode=0, or to SCAN when mode=1.
  - DIRECT or SCAN: en=0 → IDLE; on the transition, out=0 and out_valid=0.
  - Mode change while en=1 switches state on the next edge. Entering SCAN always restarts at idx=0 with the dwell counter cleared.
- in_ready = 1 only in DIRECT (combinational from state); 0 in IDLE and SCAN.
- Direct mode:
  - A transfer occurs when in_valid & in_ready.
  - One cycle later: out = 1<<in, idx = in, out_valid = 1.
  - If in ≥ NUM_OUT: out = 0, out_valid = 0, idx = in, err = 1 for exactly one cycle.
  - With no transfer, out, idx and out_valid hold.
  - Back-to-back transfers update out every cycle.
- Scan mode:
  - out = 1<<idx and out_valid = 1 from the first SCAN cycle.
  - The dwell counter counts 0..DWELL-1. At DWELL-1 it clears and idx advances.
  - At idx = NUM_OUT-1, advancing sets idx = 0 and pulses wrap in the same cycle idx becomes 0.
  - in_valid and in are ignored; err stays 0.
- out is always one-hot or all-zero; never multi-hot.
- Index arithmetic is N bits wide; NUM_OUT < 2^N must wrap at NUM_OUT-1, not at 2^N-1.
- Reset mid-scan or mid-transfer returns everything to reset values immediately. The first scan after release starts at idx 0.
- en deasserted and reasserted in SCAN restarts at idx 0 (no resume).

Optional Feature:
Macro DECODER_ACTIVE_LOW_EN.
- Defined: the out port is the bitwise inverse of the internal one-hot vector (one-cold). Reset, IDLE and error values of out become all-ones. All other outputs are unchanged.
- Undefined: out is active-high as specified above.

Test Plan:
1. Reset: hold rst_n=0 with en=1, mode=1 → out=0, out_valid=0, idx=0, wrap=0, err=0. Release, then en=1, mode=0 → in_ready=1 on the cycle after leaving IDLE.
2. Direct decode: N=4, transfers in=0,1,3,7,15 on consecutive cycles → out = 0x0001, 0x0002, 0x0008, 0x0080, 0x8000, each one cycle after its transfer, with out_valid=1.
3. Out of range: NUM_OUT=10, in=12 → next cycle out=0, out_valid=0, err=1 for one cycle, then err=0. A following in=9 gives out=0x200.
4. Scan with wrap: NUM_OUT=4, DWELL=3, mode=1 → idx sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. wrap=1 only on the cycle idx returns to 0. in_ready=0 throughout.
5. Mode/enable switching: in SCAN at idx=2, drop en for one cycle → out=0, state IDLE. Reassert en → scan restarts at idx=0. Set mode=0 → in_ready=1 and scan stops.
6. With DECODER_ACTIVE_LOW_EN defined: in=3 → out=0xFFF7. In IDLE, out=0xFFFF.

Source files
------------

// File: rtl/decoder_seq_nxm_if.sv
// Handshake and output bundle for decoder_seq_nxm.
// master drives the code side; slave is the decoder itself.
interface decoder_seq_nxm_if #(
  parameter int N       = 4,
  parameter int NUM_OUT = 1 << N
);
  logic               en;
  logic               mode;
  logic               in_valid;
  logic [N-1:0]       in;
  logic               in_ready;
  logic [NUM_OUT-1:0] out;
  logic               out_valid;
  logic [N-1:0]       idx;
  logic               wrap;
  logic               err;

  modport master (
    output en, mode, in_valid, in,
    input  in_ready, out, out_valid, idx, wrap, err
  );

  modport slave (
    input  en, mode, in_valid, in,
    output in_ready, out, out_valid, idx, wrap, err
  );
endinterface

// File: rtl/decoder_seq_nxm.sv
// Registered N-to-NUM_OUT one-hot decoder with direct (handshaked) and auto-scan modes.
// Optional macro DECODER_ACTIVE_LOW_EN makes the out port one-cold (bitwise inverted).
//
// state  | meaning
// IDLE   | disabled, out cleared
// DIRECT | accepting codes, out follows the last accepted code
// SCAN   | walking idx 0..NUM_OUT-1, DWELL cycles per output
module decoder_seq_nxm #(
  parameter int N       = 4,
  parameter int NUM_OUT = 1 << N,
  parameter int DWELL   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  decoder_seq_nxm_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam int              CW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [N-1:0]    LAST_IDX  = N'(NUM_OUT - 1);
  localparam logic [CW-1:0]   LAST_CNT  = CW'(DWELL - 1);
  localparam logic [N:0]      NUM_OUT_W = (N+1)'(NUM_OUT);

  state_t               state_q, state_d;
  logic [NUM_OUT-1:0]   out_q, out_d;
  logic                 valid_q, valid_d;
  logic [N-1:0]         idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 wrap_q, wrap_d;
  logic                 err_q, err_d;
  logic                 xfer;
  logic                 code_oor;

  // Compare against the zero-extended code so codes >= NUM_OUT never alias onto an output.
  function automatic logic [NUM_OUT-1:0] onehot(input logic [N-1:0] code);
    logic [NUM_OUT-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      v[i] = ({1'b0, code} == (N+1)'(i));
    end
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.en) begin
      state_d = IDLE;
    end else if (bus.mode) begin
      state_d = SCAN;
    end else begin
      state_d = DIRECT;
    end
  end

  assign xfer     = bus.in_valid && (state_q == DIRECT);
  assign code_oor = ({1'b0, bus.in} >= NUM_OUT_W);

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    case (state_d)
      IDLE: begin
        out_d   = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
      DIRECT: begin
        if (state_q != DIRECT) begin
          out_d   = '0;
          valid_d = 1'b0;
          cnt_d   = '0;
        end else if (xfer) begin
          idx_d = bus.in;
          if (code_oor) begin
            out_d   = '0;
            valid_d = 1'b0;
            err_d   = 1'b1;
          end else begin
            out_d   = onehot(bus.in);
            valid_d = 1'b1;
          end
        end
      end
      SCAN: begin
        // Any entry into scan restarts the walk; there is no resume.
        if (state_q != SCAN) begin
          idx_d   = '0;
          cnt_d   = '0;
          out_d   = onehot('0);
          valid_d = 1'b1;
        end else if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
          out_d   = onehot(idx_d);
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        out_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == DIRECT);
  assign bus.out_valid = valid_q;
  assign bus.idx       = idx_q;
  assign bus.wrap      = wrap_q;
  assign bus.err       = err_q;

`ifdef DECODER_ACTIVE_LOW_EN
  assign bus.out = ~out_q;
`else
  assign bus.out = out_q;
`endif

endmodule

// File: tb/tb_decoder_seq_nxm.sv
// Self-checking bench: three decoder configurations share one random/directed stimulus
// and are compared every cycle against a cycle-count based behavioural model.
module tb_decoder_seq_nxm;

`ifdef DECODER_ACTIVE_LOW_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_DIR  = 1;
  localparam int M_SCAN = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, mode, in_valid;
  logic [3:0] in;

  always #5 clk = ~clk;

  decoder_seq_nxm_if #(.N(4), .NUM_OUT(16)) ifa ();
  decoder_seq_nxm_if #(.N(4), .NUM_OUT(10)) ifb ();
  decoder_seq_nxm_if #(.N(4), .NUM_OUT(4))  ifc ();

  assign ifa.en = en;  assign ifa.mode = mode;  assign ifa.in_valid = in_valid;  assign ifa.in = in;
  assign ifb.en = en;  assign ifb.mode = mode;  assign ifb.in_valid = in_valid;  assign ifb.in = in;
  assign ifc.en = en;  assign ifc.mode = mode;  assign ifc.in_valid = in_valid;  assign ifc.in = in;

  decoder_seq_nxm #(.N(4), .NUM_OUT(16), .DWELL(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  decoder_seq_nxm #(.N(4), .NUM_OUT(10), .DWELL(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  decoder_seq_nxm #(.N(4), .NUM_OUT(4),  .DWELL(3)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  logic [15:0] d_out[3];
  logic [3:0]  d_idx[3];
  logic        d_valid[3], d_wrap[3], d_err[3], d_rdy[3];

  assign d_out[0] = ifa.out;
  assign d_out[1] = {6'b0, ifb.out};
  assign d_out[2] = {12'b0, ifc.out};
  assign d_idx[0] = ifa.idx;        assign d_idx[1] = ifb.idx;        assign d_idx[2] = ifc.idx;
  assign d_valid[0] = ifa.out_valid; assign d_valid[1] = ifb.out_valid; assign d_valid[2] = ifc.out_valid;
  assign d_wrap[0] = ifa.wrap;      assign d_wrap[1] = ifb.wrap;      assign d_wrap[2] = ifc.wrap;
  assign d_err[0] = ifa.err;        assign d_err[1] = ifb.err;        assign d_err[2] = ifc.err;
  assign d_rdy[0] = ifa.in_ready;   assign d_rdy[1] = ifb.in_ready;   assign d_rdy[2] = ifc.in_ready;

  int n_checks = 0;
  int n_pass   = 0;

  int m_mode[3], m_idx[3], m_t[3];
  bit m_valid[3], m_wrap[3], m_err[3];

  int          dcode[5] = '{0, 1, 3, 7, 15};
  logic [15:0] dexp[5]  = '{16'h0001, 16'h0002, 16'h0008, 16'h0080, 16'h8000};
  int          scan_exp[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

  function automatic int nout(input int k);
    case (k)
      0: return 16;
      1: return 10;
      default: return 4;
    endcase
  endfunction

  function automatic int ndwell(input int k);
    case (k)
      0: return 4;
      1: return 2;
      default: return 3;
    endcase
  endfunction

  // Map an active-high expectation onto the port polarity of instance k.
  function automatic logic [15:0] pol(input int k, input logic [15:0] v);
    logic [16:0] m;
    m = (17'd1 << nout(k)) - 17'd1;
    return AL ? (~v & m[15:0]) : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: scan position is derived from cycles spent in scan, direct from the last code.
  initial begin
    int want, no, dw;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        no = nout(k);
        dw = ndwell(k);
        m_wrap[k] = 1'b0;
        m_err[k]  = 1'b0;
        if (!rst_n) begin
          m_mode[k]  = M_IDLE;
          m_idx[k]   = 0;
          m_valid[k] = 1'b0;
          m_t[k]     = 0;
        end else begin
          want = !en ? M_IDLE : (mode ? M_SCAN : M_DIR);
          if (want == M_IDLE) begin
            m_valid[k] = 1'b0;
          end else if (want != m_mode[k]) begin
            if (want == M_SCAN) begin
              m_t[k] = 0;
              m_idx[k] = 0;
              m_valid[k] = 1'b1;
            end else begin
              m_valid[k] = 1'b0;
            end
          end else if (want == M_SCAN) begin
            m_t[k]++;
            m_idx[k]   = (m_t[k] / dw) % no;
            m_valid[k] = 1'b1;
            m_wrap[k]  = (m_t[k] % (dw * no)) == 0;
          end else if (in_valid) begin
            m_idx[k]   = int'(in);
            m_valid[k] = int'(in) < no;
            m_err[k]   = int'(in) >= no;
          end
          m_mode[k] = want;
        end
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("i%0d_out", k), d_out[k],
            pol(k, m_valid[k] ? (16'd1 << m_idx[k]) : 16'd0));
        chk($sformatf("i%0d_valid", k), d_valid[k], m_valid[k]);
        chk($sformatf("i%0d_idx", k), d_idx[k], m_idx[k]);
        chk($sformatf("i%0d_wrap", k), d_wrap[k], m_wrap[k]);
        chk($sformatf("i%0d_err", k), d_err[k], m_err[k]);
        chk($sformatf("i%0d_ready", k), d_rdy[k], m_mode[k] == M_DIR);
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; in_valid = 1'b0; in = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", d_out[0], pol(0, 16'h0000));
    chk("rst_valid", d_valid[0], 0);
    chk("rst_idx", d_idx[2], 0);
    chk("rst_wrap", d_wrap[2], 0);
    chk("rst_err", d_err[1], 0);
    chk("rst_ready", d_rdy[0], 0);

    rst_n = 1'b1; mode = 1'b0;
    @(negedge clk);
    chk("ready_after_idle", d_rdy[0], 1);

    for (int i = 0; i < 5; i++) begin
      in = dcode[i][3:0]; in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("dir_out_%0d", dcode[i]), d_out[0], pol(0, dexp[i]));
      chk($sformatf("dir_valid_%0d", dcode[i]), d_valid[0], 1);
      chk($sformatf("dir_idx_%0d", dcode[i]), d_idx[0], dcode[i]);
    end

    in = 4'd12; in_valid = 1'b1;
    @(negedge clk);
    chk("oor_out", d_out[1], pol(1, 16'h0000));
    chk("oor_valid", d_valid[1], 0);
    chk("oor_err", d_err[1], 1);
    chk("oor_idx", d_idx[1], 12);
    in_valid = 1'b0;
    @(negedge clk);
    chk("oor_err_clear", d_err[1], 0);
    chk("oor_hold_out", d_out[1], pol(1, 16'h0000));
    in = 4'd9; in_valid = 1'b1;
    @(negedge clk);
    chk("in9_out", d_out[1], pol(1, 16'h0200));
    chk("in9_valid", d_valid[1], 1);

    in_valid = 1'b0; mode = 1'b1;
    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      chk($sformatf("scan_idx_%0d", j), d_idx[2], scan_exp[j]);
      chk($sformatf("scan_wrap_%0d", j), d_wrap[2], j == 12);
      chk($sformatf("scan_out_%0d", j), d_out[2], pol(2, 16'd1 << scan_exp[j]));
      chk($sformatf("scan_ready_%0d", j), d_rdy[2], 0);
    end
    repeat (6) @(negedge clk);
    chk("scan_at_2", d_idx[2], 2);
    en = 1'b0;
    @(negedge clk);
    chk("drop_en_out", d_out[2], pol(2, 16'h0000));
    chk("drop_en_valid", d_valid[2], 0);
    chk("idle_out_a", d_out[0], pol(0, 16'h0000));
    en = 1'b1;
    @(negedge clk);
    chk("restart_idx", d_idx[2], 0);
    chk("restart_out", d_out[2], pol(2, 16'h0001));
    mode = 1'b0;
    @(negedge clk);
    chk("to_direct_ready", d_rdy[2], 1);

    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(199) != 0);
      if (en) en = ($urandom_range(99) != 0);
      else    en = ($urandom_range(2) == 0);
      if ($urandom_range(59) == 0) mode = ~mode;
      in_valid = $urandom_range(1);
      in = 4'($urandom_range(15));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
